dmem_responder: RTL

- Data-memory responder: the slave end of the core's data-memory port (wr, rd, addr, wr_data, rd_data).
- Accepts one load/store request at a time from the datapath.
- Holds a byte-addressed 512-byte store and returns sized, sign/zero-extended load data after a programmable number of wait states.
- Drives a ready/valid pair so the datapath can stall on MEM.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states,
// and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_t;

    // Signed and unsigned codes share the low two bits, so stores treat BU/HU as B/H.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (funct3[1:0])
            2'b00:   mask = 4'b0001 << addr_lo;
            2'b01:   mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment: load byte/half extraction with extension, store data
// replication with byte-lane mask, and size/alignment legality.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic [3:0]  store_mask,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   store_word = {4{wr_data[7:0]}};
            2'b01:   store_word = {2{wr_data[15:0]}};
            default: store_word = wr_data;
        endcase
        store_mask = lane_mask(funct3, addr_lo);
    end

    always_comb begin
        case (funct3)
            F3_B, F3_BU: illegal = 1'b0;
            F3_H, F3_HU: illegal = addr_lo[0];
            F3_W:        illegal = (addr_lo != 2'b00);
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, 512-byte store.
// Optional per-type access counters are enabled by defining DMEM_ACCESS_CNT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       load_cnt,
    output logic [31:0]       store_cnt
`endif
);

    localparam int unsigned Words    = 2 ** (ADDR_W - 2);
    localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t       state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              rd_q;
    logic              wr_q;

    logic [DATA_W-1:0] mem [Words];
    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic [3:0]        store_mask;
    logic              lane_illegal;
    logic              illegal;
    logic              commit;

    assign mem_word = mem[addr_q[ADDR_W-1:2]];
    assign illegal  = (rd_q & wr_q) | lane_illegal;
    assign commit   = (state == StResp) & ~illegal;

    dmem_lane_align u_lane_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .mem_word   (mem_word),
        .wr_data    (wr_data_q),
        .load_data  (load_data),
        .store_word (store_word),
        .store_mask (store_mask),
        .illegal    (lane_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            ready     <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            err       <= 1'b0;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            funct3_q  <= 3'b000;
            wr_data_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                StIdle: begin
                    if (ready && (rd || wr)) begin
                        addr_q    <= addr;
                        funct3_q  <= funct3;
                        wr_data_q <= wr_data;
                        rd_q      <= rd;
                        wr_q      <= wr;
                        ready     <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= StResp;
                        end else begin
                            state    <= StWait;
                            wait_cnt <= WaitInit;
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt == 4'd0) begin
                        state <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StResp: begin
                    rd_valid <= 1'b1;
                    ready    <= 1'b1;
                    state    <= StIdle;
                    if (illegal) begin
                        err     <= 1'b1;
                        rd_data <= '0;
                    end else if (rd_q) begin
                        rd_data <= load_data;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Store contents survive reset; an aborted request never reaches StResp, so it never writes.
    always_ff @(posedge clk) begin
        if (commit && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (store_mask[i]) begin
                    mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt  <= 32'd0;
            store_cnt <= 32'd0;
        end else if (commit) begin
            if (rd_q) begin
                load_cnt <= load_cnt + 32'd1;
            end else begin
                store_cnt <= store_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
